// File: rtl/life_gen_scheduler.sv
// Game-of-Life generation scheduler: paces update-engine runs against VGA
// frame starts and swaps the ping-pong cell buffer only at a frame start,
// so the display never scans out a half-written board.
module life_gen_scheduler #(
  parameter int VSPP           = 0,
  parameter int SPD_W          = 4,
  parameter int GEN_W          = 16,
  parameter int TIMEOUT_FRAMES = 4,
  parameter int TO_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             setting_status,
  input  logic [SPD_W-1:0] speed_sel,
  input  logic             ovr_clr,
  input  logic             eng_done,
  output logic             eng_start,
  output logic             eng_abort,
  output logic             buf_sel,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {PAUSE, COUNT, START, RUN, SWAP} state_t;

  localparam logic          POL      = (VSPP != 0);
  localparam logic [TO_W:0] TO_LIMIT = (TO_W + 1)'(TIMEOUT_FRAMES);

  state_t           state, state_next;
  logic             vsync_d;
  logic [SPD_W-1:0] frame_cnt, frame_next;
  logic [TO_W-1:0]  to_cnt, to_next;
  logic             step_pend, step_next;
  logic             abort_next, busy_next, toggle, timeout;
  logic             fs, go, frame_hit, to_hit;
  logic [SPD_W-1:0] target;

  // A frame starts on the first cycle vsync shows its active level.
  assign fs        = (vsync == POL) && (vsync_d != POL);
  assign go        = run_en && !setting_status;
  assign target    = (speed_sel == '0) ? SPD_W'(1) : speed_sel;
  assign frame_hit = ({1'b0, frame_cnt} + (SPD_W + 1)'(1)) == {1'b0, target};
  assign to_hit    = ({1'b0, to_cnt} + (TO_W + 1)'(1)) == TO_LIMIT;

  // Next-state and next-value decode for the scheduler FSM.
  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    to_next    = to_cnt;
    step_next  = step_pend;
    abort_next = 1'b0;
    toggle     = 1'b0;
    timeout    = 1'b0;
    case (state)
      PAUSE: begin
        if (go) begin
          state_next = COUNT;
          frame_next = '0;
        end else if (fs && step_pend) begin
          step_next  = 1'b0;
          state_next = START;
        end else if (step_req && !setting_status) begin
          step_next = 1'b1;
        end
      end
      COUNT: begin
        if (!go) begin
          state_next = PAUSE;
          frame_next = '0;
        end else if (fs) begin
          if (frame_hit) begin
            frame_next = '0;
            state_next = START;
          end else begin
            frame_next = frame_cnt + SPD_W'(1);
          end
        end
      end
      START: begin
        to_next    = '0;
        state_next = RUN;
      end
      RUN: begin
        if (eng_done) begin
          state_next = SWAP;
        end else if (fs) begin
          if (to_hit) begin
            timeout    = 1'b1;
            abort_next = 1'b1;
            state_next = go ? COUNT : PAUSE;
          end else begin
            to_next = to_cnt + TO_W'(1);
          end
        end
      end
      SWAP: begin
        if (fs) begin
          toggle     = 1'b1;
          frame_next = '0;
          state_next = go ? COUNT : PAUSE;
        end
      end
      default: state_next = PAUSE;
    endcase
    busy_next = (state_next == START) || (state_next == RUN) || (state_next == SWAP);
  end

  // Scheduler state, frame/timeout counters and pending single-step request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PAUSE;
      vsync_d   <= !POL;
      frame_cnt <= '0;
      to_cnt    <= '0;
      step_pend <= 1'b0;
    end else begin
      state     <= state_next;
      vsync_d   <= vsync;
      frame_cnt <= frame_next;
      to_cnt    <= to_next;
      step_pend <= step_next;
    end
  end

  // Registered outputs; the buffer select flips only on the frame start that leaves SWAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      busy      <= 1'b0;
      buf_sel   <= 1'b0;
      gen_count <= '0;
      overrun   <= 1'b0;
    end else begin
      eng_start <= (state_next == START);
      eng_abort <= abort_next;
      busy      <= busy_next;
      if (toggle) begin
        buf_sel   <= ~buf_sel;
        gen_count <= gen_count + GEN_W'(1);
      end
      if (timeout) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Scenario bench for life_gen_scheduler: a frame generator and engine model
// drive the DUT; expected eng_start/eng_abort/swap events are queued per
// scenario and matched by a monitor against frame index and timing.
module tb_life_gen_scheduler;

  localparam int FRAME   = 160;
  localparam int VS_LEN  = 4;
  localparam int LATENCY = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b1;
  logic        run_en = 1'b0;
  logic        step_req = 1'b0;
  logic        setting_status = 1'b0;
  logic [3:0]  speed_sel = 4'd0;
  logic        ovr_clr = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_start, eng_abort, buf_sel, busy, overrun;
  logic [15:0] gen_count;

  int   checks = 0;
  int   failures = 0;
  int   fs_num = 0;
  int   fs_at = 0;
  int   pos_cyc = 0;
  int   eng_mode = 0;
  int   exp_gen = 0;
  logic exp_buf = 1'b0;
  logic prev_buf = 1'b0;
  event fs_ev;

  typedef struct {
    int kind;
    int fs;
    int gen;
  } ev_t;
  ev_t exp_q[$];

  life_gen_scheduler #(
    .VSPP(0), .SPD_W(4), .GEN_W(16), .TIMEOUT_FRAMES(4), .TO_W(3)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .run_en(run_en),
    .step_req(step_req), .setting_status(setting_status),
    .speed_sel(speed_sel), .ovr_clr(ovr_clr), .eng_done(eng_done),
    .eng_start(eng_start), .eng_abort(eng_abort), .buf_sel(buf_sel),
    .gen_count(gen_count), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Negative-polarity vsync: each falling edge is one frame start.
  initial begin
    forever begin
      repeat (FRAME - VS_LEN) @(negedge clk);
      vsync = 1'b0;
      fs_num++;
      fs_at = pos_cyc;
      ->fs_ev;
      repeat (VS_LEN) @(negedge clk);
      vsync = 1'b1;
    end
  end

  // Engine model: mode 1 finishes after LATENCY cycles, mode 2 finishes on the next frame start.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && eng_start === 1'b1) begin
        if (eng_mode == 1) begin
          repeat (LATENCY) @(negedge clk);
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
        end else if (eng_mode == 2) begin
          @(fs_ev);
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: kinds are 0 start, 1 abort, 2 buffer swap.
  always @(posedge clk) begin
    logic [2:0] hit;
    ev_t e;
    #1;
    pos_cyc++;
    if (reset) begin
      prev_buf = buf_sel;
    end else begin
      hit = {buf_sel !== prev_buf, eng_abort === 1'b1, eng_start === 1'b1};
      for (int k = 0; k < 3; k++) begin
        if (hit[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event kind=%0d at_fs=%0d required=none", k, fs_num);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k) begin
              failures++;
              $display("[TB] FAIL event_kind got=%0d required=%0d", k, e.kind);
            end
            checks++;
            if (fs_num != e.fs) begin
              failures++;
              $display("[TB] FAIL event_frame kind=%0d got_fs=%0d required_fs=%0d", k, fs_num, e.fs);
            end
            checks++;
            if (pos_cyc != fs_at + 1) begin
              failures++;
              $display("[TB] FAIL event_timing kind=%0d got_cycles_after_fs=%0d required=1", k, pos_cyc - fs_at);
            end
            checks++;
            if (gen_count !== e.gen[15:0]) begin
              failures++;
              $display("[TB] FAIL event_gen kind=%0d got=%0d required=%0d", k, gen_count, e.gen);
            end
          end
        end
      end
      prev_buf = buf_sel;
    end
  end

  task automatic sync_fs();
    int f;
    f = fs_num;
    while (fs_num == f) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_fs(input int t);
    while (fs_num < t) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic push_ev(input int kind, input int fs, input int gen);
    ev_t e;
    e.kind = kind;
    e.fs   = fs;
    e.gen  = gen;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 6;
    if (eng_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_eng_start got=%b required=0", eng_start); end
    if (eng_abort !== 1'b0) begin failures++; $display("[TB] FAIL reset_eng_abort got=%b required=0", eng_abort); end
    if (buf_sel !== 1'b0) begin failures++; $display("[TB] FAIL reset_buf_sel got=%b required=0", buf_sel); end
    if (gen_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_gen_count got=%0d required=0", gen_count); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b required=0", busy); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b required=0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_speed3();
    int base;
    eng_mode = 1;
    sync_fs();
    base = fs_num;
    speed_sel = 4'd3;
    run_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_ev(0, base + 3 + 4 * i, exp_gen);
      exp_gen++;
      exp_buf = ~exp_buf;
      push_ev(2, base + 4 + 4 * i, exp_gen);
    end
    wait_fs(base + 3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL speed3_busy got=%b required=1", busy); end
    wait_fs(base + 12);
    run_en = 1'b0;
    wait_fs(base + 15);
    checks += 3;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL speed3_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
    if (gen_count !== exp_gen[15:0]) begin failures++; $display("[TB] FAIL speed3_gen got=%0d required=%0d", gen_count, exp_gen); end
    if (buf_sel !== exp_buf) begin failures++; $display("[TB] FAIL speed3_buf got=%b required=%b", buf_sel, exp_buf); end
  endtask

  task automatic test_speed0();
    int base;
    eng_mode = 1;
    sync_fs();
    base = fs_num;
    speed_sel = 4'd0;
    run_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_ev(0, base + 1 + 2 * i, exp_gen);
      exp_gen++;
      exp_buf = ~exp_buf;
      push_ev(2, base + 2 + 2 * i, exp_gen);
    end
    wait_fs(base + 4);
    run_en = 1'b0;
    wait_fs(base + 7);
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL speed0_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL speed0_idle_busy got=%b required=0", busy); end
  endtask

  task automatic test_step();
    int base;
    eng_mode = 1;
    sync_fs();
    base = fs_num;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    push_ev(0, base + 1, exp_gen);
    exp_gen++;
    exp_buf = ~exp_buf;
    push_ev(2, base + 2, exp_gen);
    wait_fs(base + 12);
    checks += 3;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL step_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
    if (gen_count !== exp_gen[15:0]) begin failures++; $display("[TB] FAIL step_gen got=%0d required=%0d", gen_count, exp_gen); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL step_busy got=%b required=0", busy); end
  endtask

  task automatic test_setting();
    int base;
    eng_mode = 1;
    sync_fs();
    base = fs_num;
    speed_sel = 4'd1;
    run_en = 1'b1;
    push_ev(0, base + 1, exp_gen);
    exp_gen++;
    exp_buf = ~exp_buf;
    push_ev(2, base + 2, exp_gen);
    wait_fs(base + 1);
    setting_status = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL setting_run_busy got=%b required=1", busy); end
    wait_fs(base + 2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL setting_pause_busy got=%b required=0", busy); end
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    wait_fs(base + 5);
    run_en = 1'b0;
    @(negedge clk);
    setting_status = 1'b0;
    wait_fs(base + 8);
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL setting_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
    if (gen_count !== exp_gen[15:0]) begin failures++; $display("[TB] FAIL setting_gen got=%0d required=%0d", gen_count, exp_gen); end
  endtask

  task automatic test_coincide();
    int base;
    eng_mode = 2;
    sync_fs();
    base = fs_num;
    speed_sel = 4'd1;
    run_en = 1'b1;
    push_ev(0, base + 1, exp_gen);
    wait_fs(base + 1);
    run_en = 1'b0;
    wait_fs(base + 2);
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL coincide_swap_busy got=%b required=1", busy); end
    if (gen_count !== exp_gen[15:0]) begin failures++; $display("[TB] FAIL coincide_early_gen got=%0d required=%0d", gen_count, exp_gen); end
    exp_gen++;
    exp_buf = ~exp_buf;
    push_ev(2, base + 3, exp_gen);
    wait_fs(base + 5);
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL coincide_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
    if (gen_count !== exp_gen[15:0]) begin failures++; $display("[TB] FAIL coincide_gen got=%0d required=%0d", gen_count, exp_gen); end
  endtask

  task automatic test_timeout();
    int base;
    eng_mode = 0;
    sync_fs();
    base = fs_num;
    speed_sel = 4'd1;
    run_en = 1'b1;
    push_ev(0, base + 1, exp_gen);
    push_ev(1, base + 5, exp_gen);
    wait_fs(base + 1);
    run_en = 1'b0;
    wait_fs(base + 4);
    checks += 2;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early_overrun got=%b required=0", overrun); end
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL timeout_run_busy got=%b required=1", busy); end
    wait_fs(base + 5);
    checks += 4;
    if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL timeout_overrun got=%b required=1", overrun); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_busy got=%b required=0", busy); end
    if (buf_sel !== exp_buf) begin failures++; $display("[TB] FAIL timeout_buf got=%b required=%b", buf_sel, exp_buf); end
    if (gen_count !== exp_gen[15:0]) begin failures++; $display("[TB] FAIL timeout_gen got=%0d required=%0d", gen_count, exp_gen); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_clr got=%b required=0", overrun); end
    wait_fs(base + 8);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL timeout_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_run();
    int base;
    eng_mode = 0;
    sync_fs();
    base = fs_num;
    speed_sel = 4'd1;
    run_en = 1'b1;
    push_ev(0, base + 1, exp_gen);
    wait_fs(base + 1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrun_busy got=%b required=1", busy); end
    reset = 1'b1;
    run_en = 1'b0;
    exp_gen = 0;
    exp_buf = 1'b0;
    #1;
    checks += 6;
    if (eng_start !== 1'b0) begin failures++; $display("[TB] FAIL midrun_eng_start got=%b required=0", eng_start); end
    if (eng_abort !== 1'b0) begin failures++; $display("[TB] FAIL midrun_eng_abort got=%b required=0", eng_abort); end
    if (buf_sel !== 1'b0) begin failures++; $display("[TB] FAIL midrun_buf_sel got=%b required=0", buf_sel); end
    if (gen_count !== 16'd0) begin failures++; $display("[TB] FAIL midrun_gen_count got=%0d required=0", gen_count); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrun_busy_reset got=%b required=0", busy); end
    if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL midrun_overrun got=%b required=0", overrun); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_fs(base + 4);
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL midrun_missing got=%0d required=0", exp_q.size()); exp_q.delete(); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrun_after_busy got=%b required=0", busy); end
  endtask

  // Bound the whole run so a stuck scenario still reports.
  initial begin
    #3000000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_speed3();
    test_speed0();
    test_step();
    test_setting();
    test_coincide();
    test_timeout();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_gen_scheduler.md
Name: life_gen_scheduler

Overview:
- Sequences Game-of-Life generation updates against the VGA frame timing.
- Counts frames from the display's vsync and starts the update engine at the chosen rate.
- Swaps the ping-pong cell-buffer select only at a frame start, so the scanout never shows a half-updated board.
- Handles run/pause, single-step, manual-setting freeze and engine timeout. Sits between the VGA timing generator, the update engine and the cell memories.

Parameters:
VSPP, 0, vsync pulse polarity (0 negative, 1 positive); must match the VGA timing generator
SPD_W, 4, width of speed_sel
GEN_W, 16, width of gen_count
TIMEOUT_FRAMES, 4, frame starts allowed in RUN before abort (>=1)
TO_W, 3, width of timeout counter; must hold TIMEOUT_FRAMES

Ports:
clk  input  1  system clock, same domain as the VGA timing generator
reset  input  1  asynchronous, active-high reset
vsync  input  1  vsync from the VGA timing generator, synchronous to clk
run_en  input  1  level; 1 = free-running generations
step_req  input  1  one-cycle pulse; request a single generation while paused
setting_status  input  1  level; manual edit mode, freezes scheduling
speed_sel  input  SPD_W  frames per generation; 0 treated as 1
ovr_clr  input  1  one-cycle pulse; clears overrun
eng_done  input  1  one-cycle pulse from the update engine; generation written
eng_start  output  1  one-cycle pulse; engine begins a generation, reading buf_sel and writing ~buf_sel
eng_abort  output  1  one-cycle pulse; engine must drop the current generation
buf_sel  output  1  buffer the VGA displays and the engine reads
gen_count  output  GEN_W  completed generations, wraps at 2^GEN_W
busy  output  1  1 while state is START, RUN or SWAP
overrun  output  1  sticky; set on timeout

Behaviour:
- Reset: state=PAUSE, vsync_d=!VSPP, frame_cnt=0, to_cnt=0, step_pend=0.
  - Outputs at reset: eng_start=0, eng_abort=0, buf_sel=0, gen_count=0, overrun=0, busy=0.
- fs (frame start) = (vsync==VSPP) && (vsync_d!=VSPP); vsync_d is registered every cycle.
- go = run_en && !setting_status.
- target = (speed_sel==0) ? 1 : speed_sel.
- All state and outputs are registered. eng_start = (state==START) and eng_abort are each high for exactly 1 cycle.
- PAUSE:
  - If go: -> COUNT, frame_cnt=0.
  - Else if step_req && !setting_status: step_pend=1.
  - On fs with step_pend=1: step_pend=0, -> START.
  - step_req while setting_status=1 is ignored.
- COUNT:
  - If !go: -> PAUSE, frame_cnt=0.
  - Else on fs: if frame_cnt+1==target then frame_cnt=0, -> START; else frame_cnt++.
  - step_req is ignored.
- START: 1 cycle, eng_start=1, to_cnt=0, -> RUN.
- RUN:
  - Waits for eng_done. run_en or setting_status changes do NOT abort; the generation always completes.
  - eng_done -> SWAP.
  - On fs without eng_done: to_cnt++. If to_cnt+1==TIMEOUT_FRAMES: eng_abort=1 next cycle, overrun=1, -> COUNT if go else PAUSE. buf_sel and gen_count are unchanged.
  - eng_done and fs in the same cycle: done wins, -> SWAP. That fs is not used for the swap and does not count toward timeout.
- SWAP:
  - Waits for the next fs. On fs: buf_sel toggles, gen_count++, frame_cnt=0, -> COUNT if go else PAUSE.
  - The toggle is visible the cycle after fs, i.e. during vertical blanking.
- eng_done outside RUN is ignored.
- step_req arriving during START/RUN/SWAP is dropped (step_pend is not set).
- overrun: set by timeout, cleared by ovr_clr. If both happen in the same cycle, set wins.
- Asynchronous reset mid-generation: returns to PAUSE immediately. The engine is not signalled; the engine shares the reset.
- Minimum spacing: at least 2 fs between consecutive eng_start pulses (RUN/SWAP span one fs, COUNT needs one more).
- frame_cnt width is SPD_W. gen_count wraps with no flag.

Test Plan:
- run_en=1, speed_sel=3, engine pulses eng_done 100 cycles after eng_start -> eng_start on the cycle after 3rd fs; buf_sel 0->1 and gen_count 0->1 the cycle after the following fs; pattern repeats every 4 fs.
- speed_sel=0, run_en=1 -> behaves as speed_sel=1; eng_start one cycle after the first fs; swap on the next fs.
- run_en=0, step_req pulse -> eng_start after next fs; done; swap on following fs; gen_count=1. Then back in PAUSE: no further eng_start over 10 frames.
- eng_done never asserted, TIMEOUT_FRAMES=4 -> eng_abort pulse after 4th fs in RUN; overrun=1; buf_sel unchanged. ovr_clr pulse -> overrun=0.
- eng_done coincident with fs in RUN -> no swap that cycle; swap on the next fs; gen_count +1 exactly once.
- setting_status=1 asserted mid-RUN -> generation completes and swaps, then PAUSE. step_req while setting_status=1 -> ignored. Async reset in RUN -> all outputs 0 immediately.
